pr_region_sequencer: RTL and testbench

Sequences partial reconfiguration of one of eight PR regions at a time. It drops the region's enable and waits for the region to drain. It then asserts freeze and hands the region to the PR controller, and restores freeze/enable when the controller reports completion. Software drives it through one Avalon-MM slave, and it replaces direct software writes of the region enable/freeze vectors.

---
 rtl/pr_seq_pkg.sv | 36 +++
 rtl/pr_seq_timer.sv | 26 ++
 rtl/pr_region_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_pr_region_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pr_seq_pkg.sv
// pr_seq_pkg: shared constants for the PR region sequencer.
// States, register offsets and STATUS bit positions.
package pr_seq_pkg;

    localparam int NREGIONS = 8;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_DISABLE  = 3'd1;
    localparam state_t ST_DRAIN    = 3'd2;
    localparam state_t ST_FREEZE   = 3'd3;
    localparam state_t ST_PR       = 3'd4;
    localparam state_t ST_UNFREEZE = 3'd5;
    localparam state_t ST_ENABLE   = 3'd6;

    localparam logic [1:0] REG_REQ     = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_ENABLE  = 2'd2;
    localparam logic [1:0] REG_TIMEOUT = 2'd3;

    localparam int SB_BUSY    = 0;
    localparam int SB_REGION  = 1;
    localparam int SB_STATE   = 4;
    localparam int SB_DONE    = 7;
    localparam int SB_ERROR   = 8;
    localparam int SB_REJECT  = 9;
    localparam int SB_TIMEOUT = 10;

    function automatic logic [NREGIONS-1:0] region_mask(
        input logic [2:0] r
    );
        return 8'b1 << r;
    endfunction

endpackage

// File: rtl/pr_seq_timer.sv
// pr_seq_timer: loadable 16-bit down-counter with zero flag.
// Shared by settle delays and the drain timeout.
module pr_seq_timer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic        zero
);

    logic [15:0] cnt;

    // load has priority; otherwise count down and stop at zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= 16'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != 16'd0) begin
            cnt <= cnt - 16'd1;
        end
    end

    assign zero = (cnt == 16'd0);

endmodule

// File: rtl/pr_region_sequencer.sv
// pr_region_sequencer: disable/drain/freeze/PR/unfreeze sequencer.
// Optional drain timeout: define PRSEQ_DRAIN_TIMEOUT_EN.
module pr_region_sequencer
    import pr_seq_pkg::*;
#(
    parameter logic [7:0] REGIONDEFAULT = 8'b00000011,
    parameter int         FREEZE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  avs_seq_address,
    input  logic        avs_seq_write,
    input  logic        avs_seq_read,
    input  logic [31:0] avs_seq_writedata,
    output logic [31:0] avs_seq_readdata,
    input  logic [7:0]  coe_region_idle,
    input  logic        coe_pr_done,
    input  logic        coe_pr_error,
    output logic        coe_pr_start,
    output logic [2:0]  coe_pr_region,
    output logic [7:0]  coe_region_enable,
    output logic [7:0]  coe_region_freeze
);

    localparam logic [15:0] SETTLE = 16'(FREEZE_CYCLES - 1);

    state_t      state, nxt;
    logic [2:0]  region;
    logic [7:0]  en, en_nxt, fr, mask;
    logic        pr_start, err_path;
    logic        done_f, err_f, rej_f, tmo_f;
    logic        busy, idle_r, pr_end, abort;
    logic        wr_req, wr_stat, wr_en, accept;
    logic        t_load, t_zero;
    logic [15:0] t_val;
    logic [31:0] status;
    logic        unused_wdata;

    assign busy    = (state != ST_IDLE);
    assign mask    = region_mask(region);
    assign idle_r  = coe_region_idle[region];
    assign pr_end  = coe_pr_done | coe_pr_error;
    assign wr_req  = avs_seq_write & (avs_seq_address == REG_REQ);
    assign wr_stat = avs_seq_write & (avs_seq_address == REG_STATUS);
    assign wr_en   = avs_seq_write & (avs_seq_address == REG_ENABLE);
    assign accept  = wr_req & ~busy & avs_seq_writedata[8];
    assign unused_wdata = ^avs_seq_writedata[31:9];

`ifdef PRSEQ_DRAIN_TIMEOUT_EN
    logic [15:0] tmo_lim;
    logic        wr_tmo;

    assign wr_tmo = avs_seq_write & (avs_seq_address == REG_TIMEOUT);

    // drain limit, only changeable while idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_lim <= 16'hFFFF;
        end else if (wr_tmo && !busy) begin
            tmo_lim <= avs_seq_writedata[15:0];
        end
    end

    // load L-1 so zero marks the L-th drain cycle; 0 aborts at once
    assign t_val = (state == ST_DISABLE) ?
                   ((tmo_lim == 16'd0) ? 16'd0 : tmo_lim - 16'd1) :
                   SETTLE;
`else
    assign t_val = SETTLE;
`endif

    assign t_load = (state == ST_DISABLE) |
                    ((state == ST_DRAIN) & idle_r) |
                    ((state == ST_PR) & pr_end);

    pr_seq_timer u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (t_load),
        .load_val (t_val),
        .zero     (t_zero)
    );

    // next-state decode
    always_comb begin
        nxt   = state;
        abort = 1'b0;
        case (state)
            ST_IDLE:     if (accept) nxt = ST_DISABLE;
            ST_DISABLE:  nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (idle_r) begin
                    nxt = ST_FREEZE;
`ifdef PRSEQ_DRAIN_TIMEOUT_EN
                end else if (t_zero) begin
                    nxt   = ST_IDLE;
                    abort = 1'b1;
`endif
                end
            end
            ST_FREEZE:   if (t_zero) nxt = ST_PR;
            ST_PR:       if (pr_end) nxt = ST_UNFREEZE;
            ST_UNFREEZE: if (t_zero) nxt = err_path ? ST_IDLE : ST_ENABLE;
            ST_ENABLE:   nxt = ST_IDLE;
            default:     nxt = ST_IDLE;
        endcase
    end

    // enable vector: software write with active bit masked, then FSM
    always_comb begin
        en_nxt = en;
        if (wr_en) begin
            en_nxt = busy ? ((avs_seq_writedata[7:0] & ~mask) | (en & mask))
                          : avs_seq_writedata[7:0];
        end
        if (accept) begin
            en_nxt = en_nxt & ~region_mask(avs_seq_writedata[2:0]);
        end
        if (abort || (state == ST_UNFREEZE && nxt == ST_ENABLE)) begin
            en_nxt = en_nxt | mask;
        end
    end

    // FSM state, region, freeze, start pulse and sticky flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            region   <= 3'd0;
            en       <= REGIONDEFAULT;
            fr       <= 8'd0;
            pr_start <= 1'b0;
            err_path <= 1'b0;
            done_f   <= 1'b0;
            err_f    <= 1'b0;
            rej_f    <= 1'b0;
            tmo_f    <= 1'b0;
        end else begin
            state    <= nxt;
            en       <= en_nxt;
            pr_start <= (state == ST_FREEZE) && t_zero;
            if (accept) begin
                region   <= avs_seq_writedata[2:0];
                err_path <= 1'b0;
            end
            if (state == ST_DRAIN && idle_r) fr <= fr | mask;
            if (state == ST_PR && pr_end) begin
                fr <= fr & ~mask;
                if (coe_pr_error) err_path <= 1'b1;
            end
            if (wr_stat) begin
                done_f <= 1'b0;
                err_f  <= 1'b0;
                rej_f  <= 1'b0;
                tmo_f  <= 1'b0;
            end
            if (state == ST_UNFREEZE && nxt == ST_ENABLE) done_f <= 1'b1;
            if (state == ST_PR && coe_pr_error) err_f <= 1'b1;
            if (wr_req && !accept) rej_f <= 1'b1;
            if (abort) tmo_f <= 1'b1;
        end
    end

    always_comb begin
        status = 32'd0;
        status[SB_BUSY]              = busy;
        status[SB_REGION +: 3]       = region;
        status[SB_STATE +: 3]        = state;
        status[SB_DONE]              = done_f;
        status[SB_ERROR]             = err_f;
        status[SB_REJECT]            = rej_f;
        status[SB_TIMEOUT]           = tmo_f;
    end

    // zero-wait-state read mux
    always_comb begin
        avs_seq_readdata = 32'd0;
        if (avs_seq_read) begin
            unique case (1'b1)
                (avs_seq_address == REG_REQ):
                    avs_seq_readdata = 32'd0;
                (avs_seq_address == REG_STATUS):
                    avs_seq_readdata = status;
                (avs_seq_address == REG_ENABLE):
                    avs_seq_readdata = {24'd0, en};
                (avs_seq_address == REG_TIMEOUT):
`ifdef PRSEQ_DRAIN_TIMEOUT_EN
                    avs_seq_readdata = {16'd0, tmo_lim};
`else
                    avs_seq_readdata = 32'd0;
`endif
            endcase
        end
    end

    assign coe_pr_start      = pr_start;
    assign coe_pr_region     = region;
    assign coe_region_enable = en;
    assign coe_region_freeze = fr;

endmodule

// File: tb/tb_pr_region_sequencer.sv
// tb_pr_region_sequencer: scoreboard bench for pr_region_sequencer.
// Expected values are queued by stimulus and checked at negedge.
module tb_pr_region_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  avs_seq_address;
    logic        avs_seq_write;
    logic        avs_seq_read;
    logic [31:0] avs_seq_writedata;
    logic [31:0] avs_seq_readdata;
    logic [7:0]  coe_region_idle;
    logic        coe_pr_done;
    logic        coe_pr_error;
    logic        coe_pr_start;
    logic [2:0]  coe_pr_region;
    logic [7:0]  coe_region_enable;
    logic [7:0]  coe_region_freeze;

    int checks = 0;
    int errors = 0;

    int          q_kind[$];
    logic [31:0] q_exp[$];
    string       q_name[$];

    int          mk;
    logic [31:0] mexp;
    logic [31:0] act;
    string       mn;

    pr_region_sequencer #(
        .REGIONDEFAULT (8'b00000011),
        .FREEZE_CYCLES (4)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .avs_seq_address   (avs_seq_address),
        .avs_seq_write     (avs_seq_write),
        .avs_seq_read      (avs_seq_read),
        .avs_seq_writedata (avs_seq_writedata),
        .avs_seq_readdata  (avs_seq_readdata),
        .coe_region_idle   (coe_region_idle),
        .coe_pr_done       (coe_pr_done),
        .coe_pr_error      (coe_pr_error),
        .coe_pr_start      (coe_pr_start),
        .coe_pr_region     (coe_pr_region),
        .coe_region_enable (coe_region_enable),
        .coe_region_freeze (coe_region_freeze)
    );

    always #5 clk = ~clk;

    // monitor: compare every queued expectation at the falling edge
    always @(negedge clk) begin
        while (q_kind.size() != 0) begin
            mk   = q_kind.pop_front();
            mexp = q_exp.pop_front();
            mn   = q_name.pop_front();
            case (mk)
                0:       act = avs_seq_readdata;
                1:       act = {24'd0, coe_region_enable};
                2:       act = {24'd0, coe_region_freeze};
                3:       act = {31'd0, coe_pr_start};
                default: act = {29'd0, coe_pr_region};
            endcase
            checks++;
            if (act !== mexp) begin
                errors++;
                $display("FAIL %s @%0t: got %h expected %h",
                         mn, $time, act, mexp);
            end
        end
    end

    task automatic chk(input logic [31:0] a, input logic [31:0] e,
                       input string n);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h",
                     n, $time, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        avs_seq_read  = 1'b0;
        avs_seq_write = 1'b0;
        coe_pr_done   = 1'b0;
        coe_pr_error  = 1'b0;
    endtask

    task automatic expect_v(input int k, input logic [31:0] v,
                            input string n);
        q_kind.push_back(k);
        q_exp.push_back(v);
        q_name.push_back(n);
    endtask

    task automatic outs(input logic [7:0] e, input logic [7:0] f,
                        input logic s, input string n);
        expect_v(1, {24'd0, e}, {n, ".enable"});
        expect_v(2, {24'd0, f}, {n, ".freeze"});
        expect_v(3, {31'd0, s}, {n, ".pr_start"});
    endtask

    task automatic rd_set(input logic [1:0] a, input logic [31:0] v,
                          input string n);
        avs_seq_address = a;
        avs_seq_read    = 1'b1;
        expect_v(0, v, n);
    endtask

    task automatic wr_set(input logic [1:0] a, input logic [31:0] d);
        avs_seq_address   = a;
        avs_seq_writedata = d;
        avs_seq_write     = 1'b1;
    endtask

    initial begin
        reset_n           = 1'b0;
        avs_seq_address   = 2'd0;
        avs_seq_write     = 1'b0;
        avs_seq_read      = 1'b0;
        avs_seq_writedata = 32'd0;
        coe_region_idle   = 8'hFF;
        coe_pr_done       = 1'b0;
        coe_pr_error      = 1'b0;
        tick();
        tick();

        chk({24'd0, coe_region_enable}, 32'h03, "reset.direct_enable");
        chk({24'd0, coe_region_freeze}, 32'h00, "reset.direct_freeze");
        chk({31'd0, coe_pr_start}, 32'h0, "reset.direct_start");
        outs(8'h03, 8'h00, 1'b0, "reset");
        expect_v(4, 32'd0, "reset.region");
        rd_set(2'd1, 32'h0, "reset.status");
        tick();
`ifdef PRSEQ_DRAIN_TIMEOUT_EN
        rd_set(2'd3, 32'h0000FFFF, "reset.timeout");
`else
        rd_set(2'd3, 32'h0, "reset.timeout");
`endif
        tick();
        reset_n = 1'b1;
        tick();

        // region 1 full sequence, pr_done 5 cycles after start
        wr_set(2'd0, 32'h101);
        tick();
        for (int k = 1; k <= 18; k++) begin
            outs((k >= 17) ? 8'h03 : 8'h01,
                 (k >= 3 && k <= 12) ? 8'h02 : 8'h00,
                 (k == 7), $sformatf("seq.k%0d", k));
            if (k == 1)  rd_set(2'd1, 32'h013, "seq.status_disable");
            if (k == 5)  wr_set(2'd0, 32'h100);
            if (k == 9) begin
                rd_set(2'd1, 32'h243, "seq.status_pr");
                expect_v(4, 32'd1, "seq.region");
            end
            if (k == 12) coe_pr_done = 1'b1;
            if (k == 18) rd_set(2'd1, 32'h282, "seq.status_end");
            tick();
        end

        wr_set(2'd1, 32'h0);
        tick();
        rd_set(2'd1, 32'h002, "status_clear");
        tick();

        // error + done together; stray done in FREEZE; masked ENABLE write
        wr_set(2'd0, 32'h101);
        tick();
        for (int k = 1; k <= 14; k++) begin
            outs((k <= 10) ? 8'h01 : 8'hFC,
                 (k >= 3 && k <= 8) ? 8'h02 : 8'h00,
                 (k == 7), $sformatf("err.k%0d", k));
            if (k == 4) coe_pr_done = 1'b1;
            if (k == 8) begin
                coe_pr_done  = 1'b1;
                coe_pr_error = 1'b1;
            end
            if (k == 10) wr_set(2'd2, 32'hFE);
            if (k == 13) rd_set(2'd1, 32'h102, "err.status");
            if (k == 14) expect_v(0, 32'h0, "rdata_not_reading");
            tick();
        end

        wr_set(2'd2, 32'h03);
        tick();
        outs(8'h03, 8'h00, 1'b0, "enable_write_idle");
        rd_set(2'd2, 32'h03, "enable_read");
        tick();
        wr_set(2'd1, 32'h0);
        tick();

`ifdef PRSEQ_DRAIN_TIMEOUT_EN
        // drain timeout of 10 cycles on region 0
        wr_set(2'd3, 32'd10);
        tick();
        rd_set(2'd3, 32'd10, "timeout.reg");
        tick();
        coe_region_idle = 8'h00;
        wr_set(2'd0, 32'h100);
        tick();
        for (int k = 1; k <= 13; k++) begin
            outs((k <= 11) ? 8'h02 : 8'h03, 8'h00, 1'b0,
                 $sformatf("tmo.k%0d", k));
            if (k == 6)  rd_set(2'd1, 32'h021, "tmo.status_drain");
            if (k == 13) rd_set(2'd1, 32'h400, "tmo.status_end");
            tick();
        end
        chk({24'd0, coe_region_enable}, 32'h03, "tmo.direct_enable");
        chk({24'd0, coe_region_freeze}, 32'h00, "tmo.direct_freeze");
        coe_region_idle = 8'hFF;
        wr_set(2'd1, 32'h0);
        tick();
`else
        wr_set(2'd3, 32'd10);
        tick();
        rd_set(2'd3, 32'd0, "timeout.disabled");
        tick();
`endif

        // asynchronous reset while in PR
        wr_set(2'd0, 32'h101);
        tick();
        for (int k = 1; k <= 7; k++) begin
            if (k == 7) outs(8'h01, 8'h02, 1'b1, "rst.pre");
            tick();
        end
        #1;
        reset_n = 1'b0;
        outs(8'h03, 8'h00, 1'b0, "rst.async");
        expect_v(4, 32'd0, "rst.region");
        rd_set(2'd1, 32'h0, "rst.status");
        tick();
        reset_n = 1'b1;
        tick();
        outs(8'h03, 8'h00, 1'b0, "rst.after");
        chk({24'd0, coe_region_enable}, 32'h03, "rst.direct_enable");
        tick();

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
